// File: rtl/sobel_filter_core.sv
// -----------------------------------------------------------------------------
// sobel_filter_core
//
// Streaming 3x3 Sobel edge-magnitude core. It collects nine RGB pixels (one
// 3x3 window in row-major order, p0 top-left .. p8 bottom-right). It converts
// each pixel to gray when the pixel is accepted. It then computes
// M = min(|Gx| + |Gy|, 255) and presents M replicated as {M,M,M} on a
// valid/busy output handshake.
//
// Configuration macro: SOBEL_THRESHOLD_EN
//   defined   -> M is binarized (255 if M >= 128, else 0) before replication
//   undefined -> M is output unmodified
//   Timing and handshake are identical in both builds.
//
// Ports
//   i_clk          in   1   sole clock, rising edge
//   i_rst          in   1   synchronous active-high reset
//   i_rgb_vld      in   1   input pixel valid
//   i_rgb_data     in  24   pixel, R=[7:0] G=[15:8] B=[23:16]
//   i_rgb_busy     out  1   high = pixel input not accepted this cycle
//   o_result_vld   out  1   result valid
//   o_result_data  out 24   {M,M,M}
//   o_result_busy  in   1   high = sink refuses result this cycle
//
// Timing: the 9th pixel is accepted at edge k. The window-complete flag holds
// off input for one cycle. COMPUTE registers M at edge k+2, so o_result_vld
// is first high after edge k+2.
// -----------------------------------------------------------------------------
module sobel_filter_core (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rgb_vld,
    input  logic [23:0] i_rgb_data,
    output logic        i_rgb_busy,
    output logic        o_result_vld,
    output logic [23:0] o_result_data,
    input  logic        o_result_busy
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    // Gray conversion: floor((R+G+B)/3); the 10-bit sum cannot overflow (max 765).
    function automatic logic [7:0] gray_of(input logic [23:0] px);
        logic [9:0] sum;
        sum     = {2'b00, px[7:0]} + {2'b00, px[15:8]} + {2'b00, px[23:16]};
        gray_of = 8'(sum / 10'd3);
    endfunction

    // Zero-extend a gray byte into the signed gradient domain.
    function automatic logic signed [11:0] ext(input logic [7:0] g);
        ext = $signed({4'b0000, g});
    endfunction

    // Absolute value of a gradient (|G| <= 1020, always fits).
    function automatic logic [11:0] abs12(input logic signed [11:0] v);
        abs12 = v[11] ? 12'(-v) : 12'(v);
    endfunction

    logic [1:0]  state_r, state_nx;
    logic [3:0]  cnt_r, cnt_nx;
    logic        full_r, full_nx;
    logic        busy_r, vld_r;
    logic [23:0] result_r;
    logic [7:0]  win_r [0:8];
    logic        accept_s;

    logic signed [11:0] gx_s, gy_s;
    logic [11:0]        sum_s;
    logic [7:0]         mag_s, m_out_s;

    assign accept_s = i_rgb_vld & ~busy_r;

    // Gradient and saturated magnitude from the stored gray window.
    always_comb begin
        gx_s  = (ext(win_r[2]) + (ext(win_r[5]) <<< 1) + ext(win_r[8]))
              - (ext(win_r[0]) + (ext(win_r[3]) <<< 1) + ext(win_r[6]));
        gy_s  = (ext(win_r[6]) + (ext(win_r[7]) <<< 1) + ext(win_r[8]))
              - (ext(win_r[0]) + (ext(win_r[1]) <<< 1) + ext(win_r[2]));
        sum_s = abs12(gx_s) + abs12(gy_s);
        if (sum_s > 12'd255) begin
            mag_s = 8'hFF;
        end else begin
            mag_s = sum_s[7:0];
        end
`ifdef SOBEL_THRESHOLD_EN
        if (mag_s >= 8'd128) begin
            m_out_s = 8'hFF;
        end else begin
            m_out_s = 8'h00;
        end
`else
        m_out_s = mag_s;
`endif
    end

    // Next-state logic for the COLLECT -> COMPUTE -> OUTPUT loop.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        full_nx  = full_r;
        case (state_r)
            ST_COLLECT: begin
                if (full_r) begin
                    // The window is complete; the gradient is taken next cycle.
                    full_nx  = 1'b0;
                    state_nx = ST_COMPUTE;
                end else if (accept_s) begin
                    if (cnt_r == 4'd8) begin
                        cnt_nx  = 4'd0;
                        full_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            ST_COMPUTE: begin
                state_nx = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (!o_result_busy) begin
                    state_nx = ST_COLLECT;
                end else begin
                    state_nx = ST_OUTPUT;
                end
            end
            default: begin
                state_nx = ST_COLLECT;
                cnt_nx   = 4'd0;
                full_nx  = 1'b0;
            end
        endcase
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_COLLECT;
            cnt_r   <= 4'd0;
            full_r  <= 1'b0;
            busy_r  <= 1'b0;
            vld_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            full_r  <= full_nx;
            busy_r  <= (state_nx != ST_COLLECT) | full_nx;
            vld_r   <= (state_nx == ST_OUTPUT);
        end
    end

    // Gray window storage, written at the slot given by the pixel counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= 8'd0;
            end
        end else if (accept_s && (cnt_r <= 4'd8)) begin
            win_r[cnt_r] <= gray_of(i_rgb_data);
        end
    end

    // Result register: loaded once in COMPUTE, held through OUTPUT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_r <= 24'h000000;
        end else if (state_r == ST_COMPUTE) begin
            result_r <= {m_out_s, m_out_s, m_out_s};
        end
    end

    assign i_rgb_busy    = busy_r;
    assign o_result_vld  = vld_r;
    assign o_result_data = result_r;

endmodule

// File: tb/tb_sobel_filter_core.sv
// -----------------------------------------------------------------------------
// tb_sobel_filter_core: scoreboard bench for sobel_filter_core.
// Inputs change 1 time unit after the rising edge. A monitor on the falling
// edge models accepted pixels, pushes expected results and latencies, and
// compares delivered results. It also checks the handshake properties.
// -----------------------------------------------------------------------------
module tb_sobel_filter_core;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_rgb_vld;
    logic [23:0] i_rgb_data;
    logic        i_rgb_busy;
    logic        o_result_vld;
    logic [23:0] o_result_data;
    logic        o_result_busy = 1'b0;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;

    logic sink_rand = 1'b0;
    logic sink_hold = 1'b0;

    int          exp_q[$];
    int          lat_q[$];
    int          win_m[9];
    int          nwin   = 0;
    int          n_xfer = 0;
    int          n_push = 0;
    int          n_drop = 0;
    logic [23:0] last_data = 24'h0;
    logic [23:0] pat[9];

    logic        rst_prev = 1'b0, xfer_prev = 1'b0, full_prev = 1'b0, vld_prev = 1'b0;
    logic [23:0] data_prev = 24'h0;

    sobel_filter_core dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rgb_vld     (i_rgb_vld),
        .i_rgb_data    (i_rgb_data),
        .i_rgb_busy    (i_rgb_busy),
        .o_result_vld  (o_result_vld),
        .o_result_data (o_result_data),
        .o_result_busy (o_result_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Sink: random or held busy, changed just after the rising edge.
    always @(posedge i_clk) begin
        #1;
        o_result_busy = sink_rand ? 1'($urandom_range(0, 1)) : sink_hold;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model of one window.
    function automatic int model_out();
        int gx, gy, s, m;
        gx = (win_m[2] + 2*win_m[5] + win_m[8]) - (win_m[0] + 2*win_m[3] + win_m[6]);
        gy = (win_m[6] + 2*win_m[7] + win_m[8]) - (win_m[0] + 2*win_m[1] + win_m[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        s = gx + gy;
        m = (s > 255) ? 255 : s;
`ifdef SOBEL_THRESHOLD_EN
        m = (m >= 128) ? 255 : 0;
`endif
        return (m << 16) | (m << 8) | m;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge i_clk) begin
        logic xfer, full;
        int   r, g, b;
        full = 1'b0;
        xfer = o_result_vld && !o_result_busy && !i_rst;
        if (rst_prev) begin
            check("rst_vld",  {31'd0, o_result_vld}, 32'd0);
            check("rst_data", {8'd0, o_result_data}, 32'd0);
            check("rst_busy", {31'd0, i_rgb_busy},   32'd0);
        end else begin
            if (xfer_prev) check("b2b_busy", {31'd0, i_rgb_busy}, 32'd0);
            if (full_prev) check("full_busy", {31'd0, i_rgb_busy}, 32'd1);
            if (o_result_vld) begin
                check("out_busy", {31'd0, i_rgb_busy}, 32'd1);
                if (vld_prev && !xfer_prev)
                    check("hold_data", {8'd0, o_result_data}, {8'd0, data_prev});
                else if (lat_q.size() == 0)
                    check("spurious", 32'd1, 32'd0);
                else
                    check("latency", cyc, lat_q[0]);
            end
        end
        if (xfer) begin
            n_xfer++;
            last_data = o_result_data;
            if (exp_q.size() == 0) begin
                check("unexpected", {8'd0, o_result_data}, 32'hFFFFFFFF);
            end else begin
                check("result", {8'd0, o_result_data}, exp_q.pop_front());
                void'(lat_q.pop_front());
            end
        end
        if (i_rst) begin
            n_drop += exp_q.size();
            exp_q.delete();
            lat_q.delete();
            nwin = 0;
        end else if (i_rgb_vld && !i_rgb_busy) begin
            r = int'(i_rgb_data[7:0]);
            g = int'(i_rgb_data[15:8]);
            b = int'(i_rgb_data[23:16]);
            win_m[nwin] = (r + g + b) / 3;
            nwin++;
            if (nwin == 9) begin
                exp_q.push_back(model_out());
                lat_q.push_back(cyc + 3);
                n_push++;
                nwin = 0;
                full = 1'b1;
            end
        end
        rst_prev  = i_rst;
        xfer_prev = xfer;
        full_prev = full;
        vld_prev  = o_result_vld;
        data_prev = o_result_data;
    end

    task automatic send_pixel(input logic [23:0] d);
        int n;
        i_rgb_vld  = 1'b1;
        i_rgb_data = d;
        for (n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (!i_rgb_busy) break;
        end
        if (n == 100) check("px_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
        i_rgb_vld = 1'b0;
    endtask

    // mode 0: uniform, 1: right column only, 2: bottom row only.
    task automatic set_pat(input logic [23:0] px, input int mode);
        for (int i = 0; i < 9; i++) begin
            if (mode == 0) pat[i] = px;
            else if (mode == 1) pat[i] = (i % 3 == 2) ? px : 24'h0;
            else pat[i] = (i >= 6) ? px : 24'h0;
        end
    endtask

    task automatic send_pat();
        for (int i = 0; i < 9; i++) send_pixel(pat[i]);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_result_vld) break;
        end
        if (n == 300) check("idle_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_vld();
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (o_result_vld) break;
        end
        if (n == 50) check("vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int x0;
        i_rst      = 1'b1;
        i_rgb_vld  = 1'b0;
        i_rgb_data = 24'h0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        set_pat(24'hC8C8C8, 0);
        send_pat();
        wait_idle();
        check("uniform", {8'd0, last_data}, 32'h000000);

        set_pat(24'h0A0A0A, 1);
        send_pat();
        wait_idle();
`ifdef SOBEL_THRESHOLD_EN
        check("right10", {8'd0, last_data}, 32'h000000);
`else
        check("right10", {8'd0, last_data}, 32'h282828);
`endif

        set_pat(24'h5A3C1E, 2);
        send_pat();
        wait_idle();
`ifdef SOBEL_THRESHOLD_EN
        check("bottom60", {8'd0, last_data}, 32'hFFFFFF);
`else
        check("bottom60", {8'd0, last_data}, 32'hF0F0F0);
`endif

        set_pat(24'hFFFFFF, 1);
        send_pat();
        wait_idle();
        check("saturate", {8'd0, last_data}, 32'hFFFFFF);

        // Backpressure: hold the sink for 5 cycles in OUTPUT.
        x0 = n_xfer;
        sink_hold = 1'b1;
        set_pat(24'h0A0A0A, 1);
        send_pat();
        wait_vld();
        repeat (5) begin
            @(negedge i_clk);
            check("bp_vld",  {31'd0, o_result_vld}, 32'd1);
            check("bp_busy", {31'd0, i_rgb_busy},   32'd1);
        end
        sink_hold = 1'b0;
        wait_idle();
        check("bp_one_xfer", n_xfer - x0, 32'd1);

        // Reset in the middle of a window discards the partial pixels.
        for (int i = 0; i < 4; i++) send_pixel(24'(($urandom << 1) ^ $urandom));
        pulse_reset();
        x0 = n_xfer;
        set_pat(24'h0A0A0A, 1);
        send_pat();
        wait_idle();
        check("rst_mid_xfer", n_xfer - x0, 32'd1);
`ifndef SOBEL_THRESHOLD_EN
        check("rst_mid_data", {8'd0, last_data}, 32'h282828);
`endif

        // A pending result is dropped by reset.
        x0 = n_xfer;
        sink_hold = 1'b1;
        set_pat(24'hFFFFFF, 1);
        send_pat();
        wait_vld();
        @(posedge i_clk);
        #1;
        pulse_reset();
        sink_hold = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        check("drop_xfer", n_xfer - x0, 32'd0);

        // Streaming: gaps between pixels, random sink backpressure.
        sink_rand = 1'b1;
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 9; i++) begin
                send_pixel(24'($urandom));
                @(posedge i_clk);
                #1;
            end
        end
        wait_idle();
        sink_rand = 1'b0;
        wait_idle();

        check("leftover", exp_q.size(), 32'd0);
        check("xfer_count", n_xfer, n_push - n_drop);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sobel_filter_core.md
SOBEL_FILTER_CORE -- requirements
Module: SobelFilter

Interface
REQ-001 SHALL provide: i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide: i_rst  in  1  reset; synchronous to i_clk, active-high.
REQ-003 SHALL provide: i_rgb_vld  in  1  input pixel valid.
REQ-004 SHALL provide: i_rgb_data  in  24  pixel; R=[7:0], G=[15:8], B=[23:16], unsigned.
REQ-005 SHALL provide: i_rgb_busy  out  1  high = pixel input not accepted this cycle.
REQ-006 SHALL provide: o_result_vld  out  1  result valid.
REQ-007 SHALL provide: o_result_data  out  24  result; magnitude byte M replicated as {M,M,M}.
REQ-008 SHALL provide: o_result_busy  in  1  high = sink refuses result this cycle.

Function
REQ-009 SHALL accept a pixel on a rising edge where i_rgb_vld=1 and i_rgb_busy=0; no other input transfer.
REQ-010 SHALL deliver a result on a rising edge where o_result_vld=1 and o_result_busy=0.
REQ-011 SHALL consume 9 accepted pixels per result: a 3x3 window in row-major order, p0..p8 (p0 top-left, p8 bottom-right).
REQ-012 SHALL convert each pixel to gray g = floor((R+G+B)/3), 8 bits, at acceptance.
REQ-013 SHALL compute Gx = (g2+2*g5+g8)-(g0+2*g3+g6) and Gy = (g6+2*g7+g8)-(g0+2*g1+g2), each 11-bit signed (range +/-1020).
REQ-014 SHALL compute M = min(|Gx|+|Gy|, 255); the 12-bit sum saturates and never wraps.
REQ-015 SHALL implement FSM COLLECT -> COMPUTE -> OUTPUT -> COLLECT.
REQ-016 COLLECT: i_rgb_busy=0; 4-bit counter 0..8 increments per accepted pixel; the 9th acceptance moves to COMPUTE and clears the counter.
REQ-017 COMPUTE: exactly one cycle; i_rgb_busy=1; registers M into the output register.
REQ-018 OUTPUT: o_result_vld=1, i_rgb_busy=1; o_result_data held stable until accepted; on acceptance move to COLLECT.
REQ-019 Latency SHALL be fixed: 9th pixel accepted at edge k -> o_result_vld first high after edge k+2.
REQ-020 Back-to-back: i_rgb_busy SHALL be 0 in the cycle following result acceptance.
REQ-021 SHALL keep o_result_vld=0 in COLLECT and COMPUTE; i_rgb_vld while busy is ignored.
REQ-022 A partial window (<9 pixels) SHALL never produce output.

Reset
REQ-023 While i_rst=1 at a rising edge: state=COLLECT, counter=0, window cleared, o_result_vld=0, o_result_data=24'h000000, i_rgb_busy=0 after reset.
REQ-024 Reset SHALL take priority over any simultaneous transfer; pixels accepted before reset are discarded.
REQ-025 A pending unaccepted result SHALL be dropped on reset.

Configuration
REQ-026 Macro SOBEL_THRESHOLD_EN: when defined, M is binarized (M'=255 if M>=128, else 0) before replication; when undefined, M is output unmodified; timing and handshake are identical in both builds.

Verification
REQ-027 Uniform window, all pixels 24'hC8C8C8 -> o_result_data=24'h000000.
REQ-028 Right column RGB(10,10,10), rest 0 -> Gx=40, Gy=0 -> 24'h282828 (threshold build: 24'h000000).
REQ-029 Bottom row RGB(30,60,90) (g=60), rest 0 -> Gy=240 -> 24'hF0F0F0 (threshold build: 24'hFFFFFF); right column 24'hFFFFFF, rest 0 -> Gx=1020 -> saturated 24'hFFFFFF.
REQ-030 Backpressure: hold o_result_busy=1 for 5 cycles in OUTPUT -> o_result_vld and data stable, i_rgb_busy=1 throughout, exactly one transfer after release.
REQ-031 Reset mid-window: 4 pixels, pulse i_rst for 1 cycle, then 9 pixels of REQ-028 -> single result 24'h282828 at latency per REQ-019.
REQ-032 Streaming with i_rgb_vld toggling every cycle and random o_result_busy -> results match REQ-012..014 model per window, none lost or duplicated.
